hex_display_sequencer: RTL and testbench



---
 rtl/hex_disp_pkg.sv | 14 +
 rtl/hex_decoder.sv | 30 +++
 rtl/hex_display_sequencer.sv | 122 ++++++++++++
 tb/tb_hex_display_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types and constants for the hex display sequencer
package hex_disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int         DIGIT_W   = 4;
   localparam int         SEG_W     = 7;

endpackage

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - hex nibble to active-low seven-segment pattern (bit 0 = segment a, bit 6 = g)
module hex_decoder (
   input  logic [3:0] in,
   output logic [6:0] out
);

   always_comb begin
      out = 7'h7F;
      case (in)
         4'h0: out = 7'h40;
         4'h1: out = 7'h79;
         4'h2: out = 7'h24;
         4'h3: out = 7'h30;
         4'h4: out = 7'h19;
         4'h5: out = 7'h12;
         4'h6: out = 7'h02;
         4'h7: out = 7'h78;
         4'h8: out = 7'h00;
         4'h9: out = 7'h10;
         4'hA: out = 7'h08;
         4'hB: out = 7'h03;
         4'hC: out = 7'h46;
         4'hD: out = 7'h21;
         4'hE: out = 7'h06;
         4'hF: out = 7'h0E;
         default: out = 7'h7F;
      endcase
   end

endmodule

// File: rtl/hex_display_sequencer.sv
// rtl/hex_display_sequencer.sv - scans a packed hex word MSD-first into per-digit segment registers
// through one shared decoder; HEX_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module hex_display_sequencer
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] in_data,
   input  logic [NUM_DIGITS-1:0]         in_blank,
   output logic [SEG_W*NUM_DIGITS-1:0]   seg,
   output logic                          busy,
   output logic                          done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_t                        state, state_nxt;
   logic [DIGIT_W*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]         mask_q;
   logic [IDX_W-1:0]              idx;
   logic [SEG_W*NUM_DIGITS-1:0]   seg_q;
   logic [DIGIT_W-1:0]            nibble;
   logic                          mask_bit;
   logic                          blank_cur;
   logic [SEG_W-1:0]              dec_out;
   logic [SEG_W-1:0]              digit_seg;
   logic                          accept;

   assign accept = in_valid && (state == IDLE);
   assign seg    = seg_q;

   always_comb begin
      nibble   = '0;
      mask_bit = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nibble   = data_q[k*DIGIT_W +: DIGIT_W];
            mask_bit = mask_q[k];
         end
      end
   end

   hex_decoder u_dec (
      .in  (nibble),
      .out (dec_out)
   );

`ifdef HEX_LEADING_ZERO_BLANK_EN
   logic seen_nonzero;

   // Digit 0 always shows, so an all-zero word still displays a single 0.
   assign blank_cur = mask_bit || ((nibble == '0) && !seen_nonzero && (idx != '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_nonzero <= 1'b0;
      end else if (accept) begin
         seen_nonzero <= 1'b0;
      end else if (state == SCAN) begin
         seen_nonzero <= seen_nonzero || (nibble != '0);
      end
   end
`else
   assign blank_cur = mask_bit;
`endif

   assign digit_seg = blank_cur ? SEG_BLANK : dec_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SCAN;
         end
         SCAN: begin
            busy = 1'b1;
            if (idx == '0) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // idx stops at 0 when the FSM leaves SCAN, so the decrement never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         mask_q <= '0;
         idx    <= '0;
         seg_q  <= '1;
      end else if (accept) begin
         data_q <= in_data;
         mask_q <= in_blank;
         idx    <= IDX_W'(NUM_DIGITS - 1);
      end else if (state == SCAN) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) seg_q[k*SEG_W +: SEG_W] <= digit_seg;
         end
         if (idx != '0) idx <= idx - 1'b1;
      end
   end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// tb/tb_hex_display_sequencer.sv - scoreboard bench for hex_display_sequencer
module tb_hex_display_sequencer;

   localparam int ND = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [4*ND-1:0] in_data;
   logic [ND-1:0]   in_blank;
   logic [7*ND-1:0] seg;
   logic            busy;
   logic            done;

   int              checks = 0;
   int              errors = 0;
   int              done_count = 0;
   logic [7*ND-1:0] exp_q[$];
   logic [7*ND-1:0] mon_exp;

   always #5 clk = ~clk;

   hex_display_sequencer #(.NUM_DIGITS(ND)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_blank (in_blank),
      .seg      (seg),
      .busy     (busy),
      .done     (done)
   );

   function automatic logic [6:0] ref_dec(input logic [3:0] n);
      logic [6:0] r;
      case (n)
         4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
         4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
         4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
         4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; default: r = 7'h0E;
      endcase
      return r;
   endfunction

   function automatic logic [7*ND-1:0] ref_word(input logic [4*ND-1:0] d, input logic [ND-1:0] b);
      logic [7*ND-1:0] r;
      logic [3:0]      n;
      logic            blk;
`ifdef HEX_LEADING_ZERO_BLANK_EN
      logic            seen;
      seen = 1'b0;
`endif
      r = '1;
      for (int k = ND - 1; k >= 0; k--) begin
         n   = d[4*k +: 4];
         blk = b[k];
`ifdef HEX_LEADING_ZERO_BLANK_EN
         if (n == 4'h0 && !seen && k != 0) blk = 1'b1;
         if (n != 4'h0) seen = 1'b1;
`endif
         r[7*k +: 7] = blk ? 7'h7F : ref_dec(n);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && done === 1'b1) begin
         done_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done pulse with empty scoreboard, seg=%h", seg);
         end else begin
            mon_exp = exp_q.pop_front();
            if (seg !== mon_exp) begin
               errors++;
               $display("FAIL scoreboard_seg: got %h expected %h", seg, mon_exp);
            end
         end
      end
   end

   task automatic drive_word(input logic [4*ND-1:0] d, input logic [ND-1:0] b);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_blank = b;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      exp_q.push_back(ref_word(d, b));
      @(posedge clk);
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_blank = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks += 4;
      if (seg !== 42'h3FFFFFFFFFF) begin errors++; $display("FAIL reset_seg: got %h required 3ffffffffff", seg); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
   endtask

   task automatic test_basic();
      logic [6:0] exp_d[6];
      exp_d = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
      drive_word(24'h012345, 6'b000000);
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_scan_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk);
         #1;
         checks++;
         if (seg[7*(5-j) +: 7] !== exp_d[j]) begin
            errors++;
            $display("FAIL basic_digit%0d: got %h required %h at E%0d", 5 - j, seg[7*(5-j) +: 7], exp_d[j], j + 1);
         end
         if (j == 0) begin
            checks++;
            if (seg[6:0] !== 7'h7F) begin
               errors++;
               $display("FAIL basic_hold_digit0: got %h required 7f", seg[6:0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_cycle: done=%b in_ready=%b busy=%b required 1/0/0", done, in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_after_done: done=%b in_ready=%b required 0/1", done, in_ready);
      end
   endtask

   task automatic test_blank();
      logic [6:0] exp_d[6];
      exp_d = '{7'h7F, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};
      drive_word(24'hABCDEF, 6'b100001);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done();
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (seg[7*(5-j) +: 7] !== exp_d[j]) begin
            errors++;
            $display("FAIL blank_digit%0d: got %h required %h", 5 - j, seg[7*(5-j) +: 7], exp_d[j]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int dc0;
      int n = 0;
      dc0 = done_count;
      drive_word(24'h135790, 6'b000000);
      @(negedge clk);
      in_data = 24'h999999;
      while (in_ready !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL b2b_ready_low: in_ready low for %0d cycles, required 7", n);
      end
      exp_q.push_back(ref_word(24'h999999, 6'b000000));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done();
      @(negedge clk);
      checks += 2;
      if (seg !== {6{7'h10}}) begin
         errors++;
         $display("FAIL b2b_seg: got %h required %h", seg, {6{7'h10}});
      end
      if (done_count - dc0 !== 2) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d pulses required 2", done_count - dc0);
      end
   endtask

   task automatic test_reset_midscan();
      int dc0;
      dc0 = done_count;
      drive_word(24'h777777, 6'b000000);
      void'(exp_q.pop_back());
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks += 4;
      if (seg !== 42'h3FFFFFFFFFF) begin errors++; $display("FAIL midscan_seg: got %h required 3ffffffffff", seg); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midscan_in_ready: got %b required 1", in_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midscan_busy: got %b required 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL midscan_done: got %b required 0", done); end
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (done_count !== dc0) begin
         errors++;
         $display("FAIL midscan_no_done: got %0d pulses required 0", done_count - dc0);
      end
   endtask

`ifdef HEX_LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      logic [6:0] exp_a[6];
      logic [6:0] exp_z[6];
      exp_a = '{7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40};
      exp_z = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
      drive_word(24'h000A00, 6'b000000);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done();
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (seg[7*(5-j) +: 7] !== exp_a[j]) begin
            errors++;
            $display("FAIL lz_000a00_digit%0d: got %h required %h", 5 - j, seg[7*(5-j) +: 7], exp_a[j]);
         end
      end
      @(negedge clk);
      drive_word(24'h000000, 6'b000000);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done();
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (seg[7*(5-j) +: 7] !== exp_z[j]) begin
            errors++;
            $display("FAIL lz_000000_digit%0d: got %h required %h", 5 - j, seg[7*(5-j) +: 7], exp_z[j]);
         end
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_blank();
      test_back_to_back();
      test_reset_midscan();
`ifdef HEX_LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
